// File: rtl/iq_window_integrator_if.sv
// iq_window_integrator_if: start/abort/window control, lane samples and integrated I/Q result bundle.
interface iq_window_integrator_if #(
  parameter int LANES  = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 11
);
  logic                    start;
  logic                    abort;
  logic [LEN_W-1:0]        sample_length;
  logic [LANES-1:0]        lane_valid;
  logic [LANES*DATA_W-1:0] data_i;
  logic [LANES*DATA_W-1:0] data_q;
  logic                    busy;
  logic                    iq_valid;
  logic [ACC_W-1:0]        i_val;
  logic [ACC_W-1:0]        q_val;
  logic                    overflow;
  modport master (
    output start, abort, sample_length, lane_valid, data_i, data_q,
    input  busy, iq_valid, i_val, q_val, overflow
  );
  modport slave (
    input  start, abort, sample_length, lane_valid, data_i, data_q,
    output busy, iq_valid, i_val, q_val, overflow
  );
endinterface

// File: rtl/iq_window_integrator.sv
// iq_window_integrator: integrates LANES masked I/Q samples per beat over a programmable window.
// Define IQ_WINDOW_INTEGRATOR_SATURATE_EN to clamp the accumulators and report overflow.
module iq_window_integrator #(
  parameter int LANES  = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 11
) (
  input logic clk_100,
  input logic reset,
  iq_window_integrator_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] INTEG = 1'b1;
`ifdef IQ_WINDOW_INTEGRATOR_SATURATE_EN
  localparam logic signed [ACC_W+1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};
`endif
  logic [0:0] state;
  logic [LEN_W-1:0] len, cnt;
  logic signed [ACC_W-1:0] acc_i, acc_q, nxt_i, nxt_q, i_r, q_r;
  logic signed [ACC_W:0] sum_i, sum_q;
  logic clip_i, clip_q, sat, iq_valid_r, ovf_r;
  // returns {clipped, next accumulator}
  function automatic logic [ACC_W:0] step(input logic signed [ACC_W-1:0] a,
                                          input logic signed [ACC_W:0] b);
    logic signed [ACC_W+1:0] s;
    s = a + b;
`ifdef IQ_WINDOW_INTEGRATOR_SATURATE_EN
    return s > SAT_MAX ? {1'b1, SAT_MAX[ACC_W-1:0]} :
           s < SAT_MIN ? {1'b1, SAT_MIN[ACC_W-1:0]} : {1'b0, s[ACC_W-1:0]};
`else
    return {1'b0, s[ACC_W-1:0]};
`endif
  endfunction
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_i = sum_i + (bus.lane_valid[k] ? (ACC_W+1)'(signed'(bus.data_i[k*DATA_W +: DATA_W])) : '0);
      sum_q = sum_q + (bus.lane_valid[k] ? (ACC_W+1)'(signed'(bus.data_q[k*DATA_W +: DATA_W])) : '0);
    end
    {clip_i, nxt_i} = step(acc_i, sum_i);
    {clip_q, nxt_q} = step(acc_q, sum_q);
  end
  always_ff @(posedge clk_100) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      cnt        <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      sat        <= 1'b0;
      iq_valid_r <= 1'b0;
      i_r        <= '0;
      q_r        <= '0;
      ovf_r      <= 1'b0;
    end else begin
      iq_valid_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && !bus.abort) begin
          len   <= bus.sample_length;
          cnt   <= '0;
          acc_i <= '0;
          acc_q <= '0;
          sat   <= 1'b0;
          if (bus.sample_length == '0) begin
            iq_valid_r <= 1'b1;
            i_r        <= '0;
            q_r        <= '0;
            ovf_r      <= 1'b0;
          end else begin
            state <= INTEG;
          end
        end
      end else if (bus.abort) begin
        state <= IDLE;
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
        sat   <= 1'b0;
      end else begin
        acc_i <= nxt_i;
        acc_q <= nxt_q;
        sat   <= sat | clip_i | clip_q;
        cnt   <= cnt + 1'b1;
        if (cnt == len - 1'b1) begin
          state      <= IDLE;
          iq_valid_r <= 1'b1;
          i_r        <= nxt_i;
          q_r        <= nxt_q;
          ovf_r      <= sat | clip_i | clip_q;
        end
      end
    end
  end
  assign bus.busy     = state == INTEG;
  assign bus.iq_valid = iq_valid_r;
  assign bus.i_val    = i_r;
  assign bus.q_val    = q_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_iq_window_integrator.sv
// tb_iq_window_integrator: directed checks of windowing, masking, abort, back-to-back and wrap/saturation.
module tb_iq_window_integrator;
  logic clk_100 = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  iq_window_integrator_if #(.ACC_W(32)) if0 ();
  iq_window_integrator_if #(.ACC_W(20)) if1 ();
  iq_window_integrator #(.ACC_W(32)) dut0 (.clk_100(clk_100), .reset(reset), .bus(if0.slave));
  iq_window_integrator #(.ACC_W(20)) dut1 (.clk_100(clk_100), .reset(reset), .bus(if1.slave));
  always #5 clk_100 = ~clk_100;

  task automatic tick;
    @(posedge clk_100);
    #1;
  endtask

  task automatic set0(input logic signed [15:0] iv, input logic signed [15:0] qv);
    for (int k = 0; k < 5; k++) begin
      if0.data_i[k*16 +: 16] = iv;
      if0.data_q[k*16 +: 16] = qv;
    end
  endtask

  task automatic run_window0(input int len, input logic signed [15:0] iv, input logic signed [15:0] qv);
    set0(iv, qv);
    if0.lane_valid = 5'b11111;
    if0.sample_length = 11'(len);
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    for (int n = 0; n < len; n++) tick;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", if0.busy); end
    checks++; if (if0.iq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", if0.iq_valid); end
    checks++; if (if0.i_val !== 32'd0 || if0.q_val !== 32'd0) begin errors++; $display("FAIL reset_iq got %0d/%0d exp 0/0", if0.i_val, if0.q_val); end
    checks++; if (if0.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", if0.overflow); end
    reset = 1'b0;
    set0(16'sd3, 16'sd4);
    if0.sample_length = 11'd10;
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_pre got %0b exp 1", if0.busy); end
    repeat (3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b exp 0", if0.busy); end
    for (int n = 0; n < 12; n++) begin
      checks++; if (if0.iq_valid !== 1'b0) begin errors++; $display("FAIL midreset_novalid got %0b exp 0 at %0d", if0.iq_valid, n); end
      tick;
    end
    checks++; if (if0.i_val !== 32'd0 || if0.q_val !== 32'd0) begin errors++; $display("FAIL midreset_iq got %0d/%0d exp 0/0", if0.i_val, if0.q_val); end
  endtask

  task automatic test_basic;
    set0(16'sd100, -16'sd50);
    if0.lane_valid = 5'b11111;
    if0.sample_length = 11'd4;
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++; if (if0.busy !== 1'b1 || if0.iq_valid !== 1'b0) begin errors++; $display("FAIL basic_busy got %0b/%0b exp 1/0 at %0d", if0.busy, if0.iq_valid, n); end
      tick;
    end
    checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_last got %0b exp 1", if0.busy); end
    tick;
    checks++; if (if0.iq_valid !== 1'b1 || if0.busy !== 1'b0) begin errors++; $display("FAIL basic_valid got %0b/%0b exp 1/0", if0.iq_valid, if0.busy); end
    checks++; if ($signed(if0.i_val) !== 2000 || $signed(if0.q_val) !== -1000) begin errors++; $display("FAIL basic_iq got %0d/%0d exp 2000/-1000", $signed(if0.i_val), $signed(if0.q_val)); end
    tick;
    checks++; if (if0.iq_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0b exp 0", if0.iq_valid); end
    checks++; if ($signed(if0.i_val) !== 2000) begin errors++; $display("FAIL basic_hold got %0d exp 2000", $signed(if0.i_val)); end
  endtask

  task automatic test_lane_mask;
    for (int k = 0; k < 5; k++) begin
      if0.data_i[k*16 +: 16] = 16'(k + 1);
      if0.data_q[k*16 +: 16] = 16'(-(k + 1));
    end
    if0.lane_valid = 5'b10101;
    if0.sample_length = 11'd3;
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    repeat (3) tick;
    checks++; if (if0.iq_valid !== 1'b1 || $signed(if0.i_val) !== 27 || $signed(if0.q_val) !== -27) begin errors++; $display("FAIL mask_iq got v=%0b %0d/%0d exp 1 27/-27", if0.iq_valid, $signed(if0.i_val), $signed(if0.q_val)); end
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    tick;
    if0.lane_valid = 5'b00000;
    tick;
    if0.lane_valid = 5'b10101;
    checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL mask_gap_busy got %0b exp 1", if0.busy); end
    tick;
    checks++; if (if0.iq_valid !== 1'b1 || $signed(if0.i_val) !== 18) begin errors++; $display("FAIL mask_gap_iq got v=%0b %0d exp 1 18", if0.iq_valid, $signed(if0.i_val)); end
  endtask

  task automatic test_zero_back_to_back;
    if0.sample_length = 11'd0;
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    checks++; if (if0.iq_valid !== 1'b1 || if0.busy !== 1'b0) begin errors++; $display("FAIL zero_valid got %0b/%0b exp 1/0", if0.iq_valid, if0.busy); end
    checks++; if (if0.i_val !== 32'd0 || if0.q_val !== 32'd0 || if0.overflow !== 1'b0) begin errors++; $display("FAIL zero_iq got %0d/%0d ovf %0b exp 0/0 0", if0.i_val, if0.q_val, if0.overflow); end
    tick;
    checks++; if (if0.iq_valid !== 1'b0 || if0.busy !== 1'b0) begin errors++; $display("FAIL zero_after got %0b/%0b exp 0/0", if0.iq_valid, if0.busy); end
    run_window0(1, 16'sd7, 16'sd0);
    checks++; if (if0.iq_valid !== 1'b1 || $signed(if0.i_val) !== 35) begin errors++; $display("FAIL b2b_first got v=%0b %0d exp 1 35", if0.iq_valid, $signed(if0.i_val)); end
    set0(16'sd1, 16'sd2);
    if0.sample_length = 11'd2;
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    checks++; if (if0.busy !== 1'b1 || if0.iq_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept got %0b/%0b exp 1/0", if0.busy, if0.iq_valid); end
    tick;
    checks++; if (if0.iq_valid !== 1'b0) begin errors++; $display("FAIL b2b_early got %0b exp 0", if0.iq_valid); end
    tick;
    checks++; if (if0.iq_valid !== 1'b1 || $signed(if0.i_val) !== 10 || $signed(if0.q_val) !== 20) begin errors++; $display("FAIL b2b_second got v=%0b %0d/%0d exp 1 10/20", if0.iq_valid, $signed(if0.i_val), $signed(if0.q_val)); end
  endtask

  task automatic test_abort_ignore;
    run_window0(4, 16'sd100, -16'sd50);
    checks++; if ($signed(if0.i_val) !== 2000) begin errors++; $display("FAIL abort_prev got %0d exp 2000", $signed(if0.i_val)); end
    if0.sample_length = 11'd8;
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    repeat (2) tick;
    if0.abort = 1'b1;
    tick;
    if0.abort = 1'b0;
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", if0.busy); end
    for (int n = 0; n < 10; n++) begin
      checks++; if (if0.iq_valid !== 1'b0) begin errors++; $display("FAIL abort_novalid got %0b exp 0 at %0d", if0.iq_valid, n); end
      tick;
    end
    checks++; if ($signed(if0.i_val) !== 2000 || $signed(if0.q_val) !== -1000) begin errors++; $display("FAIL abort_hold got %0d/%0d exp 2000/-1000", $signed(if0.i_val), $signed(if0.q_val)); end
    if0.sample_length = 11'd3;
    if0.start = 1'b1;
    if0.abort = 1'b1;
    tick;
    if0.start = 1'b0;
    if0.abort = 1'b0;
    checks++; if (if0.busy !== 1'b0 || if0.iq_valid !== 1'b0) begin errors++; $display("FAIL abort_start got %0b/%0b exp 0/0", if0.busy, if0.iq_valid); end
    set0(16'sd1, 16'sd1);
    if0.sample_length = 11'd2;
    if0.start = 1'b1;
    tick;
    if0.sample_length = 11'd5;
    tick;
    if0.start = 1'b0;
    tick;
    checks++; if (if0.iq_valid !== 1'b1 || $signed(if0.i_val) !== 10) begin errors++; $display("FAIL ignore_start got v=%0b %0d exp 1 10", if0.iq_valid, $signed(if0.i_val)); end
    tick;
    checks++; if (if0.busy !== 1'b0 || if0.iq_valid !== 1'b0) begin errors++; $display("FAIL ignore_idle got %0b/%0b exp 0/0", if0.busy, if0.iq_valid); end
  endtask

  task automatic test_overflow;
    int exp_i;
    bit seen;
    logic exp_ovf;
`ifdef IQ_WINDOW_INTEGRATOR_SATURATE_EN
    exp_i = 524287;
    exp_ovf = 1'b1;
`else
    exp_i = 524208;
    exp_ovf = 1'b0;
`endif
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if1.data_i[k*16 +: 16] = 16'sd32767;
      if1.data_q[k*16 +: 16] = -16'sd32768;
    end
    if1.lane_valid = 5'b11111;
    if1.sample_length = 11'd16;
    if1.start = 1'b1;
    tick;
    if1.start = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick;
      seen = if1.iq_valid;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ovf_timeout got %0b exp 1", seen); end
    checks++; if ($signed(if1.i_val) !== exp_i || $signed(if1.q_val) !== -524288) begin errors++; $display("FAIL ovf_iq got %0d/%0d exp %0d/-524288", $signed(if1.i_val), $signed(if1.q_val), exp_i); end
    checks++; if (if1.overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag got %0b exp %0b", if1.overflow, exp_ovf); end
  endtask

  initial begin
    if0.start = 1'b0; if0.abort = 1'b0; if0.sample_length = '0; if0.lane_valid = '0; if0.data_i = '0; if0.data_q = '0;
    if1.start = 1'b0; if1.abort = 1'b0; if1.sample_length = '0; if1.lane_valid = '0; if1.data_i = '0; if1.data_q = '0;
    test_reset;
    test_basic;
    test_lane_mask;
    test_zero_back_to_back;
    test_abort_ignore;
    test_overflow;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
